// File: rtl/cpu_prog_loader_pkg.sv
// Shared types for the program loader: FSM states and payload limit.
// The CHK state only exists when CPU_LOADER_CHECKSUM_EN is defined.
package cpu_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef CPU_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int LOADER_ADDR_W = 4;

    function automatic int max_payload(input int aw);
        return 1 << aw;
    endfunction

    localparam int LOADER_MAX_PAYLOAD = max_payload(LOADER_ADDR_W);

endpackage

// File: rtl/cpu_prog_loader_if.sv
// Host handshake, instruction-memory write port and core status bundle.
// master = host/system side, slave = loader.
interface cpu_prog_loader_if #(
    parameter int ADDR_W = 4
);
    logic              load_req;
    logic              stb_in;
    logic [7:0]        data_in;
    logic              ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              err;

    modport master (
        output load_req, stb_in, data_in,
        input  ack, mem_we, mem_addr, mem_wdata,
        input  cpu_run, busy, err
    );

    modport slave (
        input  load_req, stb_in, data_in,
        output ack, mem_we, mem_addr, mem_wdata,
        output cpu_run, busy, err
    );
endinterface

// File: rtl/cpu_prog_loader_sync_edge.sv
// Multi-flop synchroniser with a delayed level and a registered rise pulse.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_edge;
    logic              r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_edge <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_edge <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_edge;
        end
    end

    assign o_level = r_edge;
    assign o_rise  = r_rise;

endmodule

// File: rtl/cpu_prog_loader.sv
// Framed byte-stream loader: length, payload, optional XOR checksum byte.
// Define CPU_LOADER_CHECKSUM_EN to require the trailing checksum.
module cpu_prog_loader
    import cpu_loader_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_prog_loader_if.slave bus
);

    localparam int         CW      = ADDR_W + 1;
    localparam logic [8:0] MAX_LEN = 9'(max_payload(ADDR_W));

    loader_state_t r_state, w_next;

    logic              w_cap, w_stb_lvl;
    logic              w_ld_rise, w_ld_lvl;
    logic              w_start, w_wr, w_store_len, w_busy;
    logic [8:0]        w_len9;
    logic              w_len_ok;
    logic [CW-1:0]     w_cnt_inc;
    logic              w_last;

    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_len;
    logic              r_ack;
    logic              r_we;
    logic              r_run;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
`ifdef CPU_LOADER_CHECKSUM_EN
    logic [7:0]        r_chk;
`endif

    sync_edge #(.STAGES(SYNC_STAGES)) u_stb_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (bus.stb_in),
        .o_level (w_stb_lvl),
        .o_rise  (w_cap)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_ld_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (bus.load_req),
        .o_level (w_ld_lvl),
        .o_rise  (w_ld_rise)
    );

    assign w_len9    = {1'b0, bus.data_in};
    assign w_len_ok  = (w_len9 != 9'd0) && (w_len9 <= MAX_LEN);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = (w_cnt_inc == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // A dropped load_req is checked first so an abort beats a capture.
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_wr        = 1'b0;
        w_store_len = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_ld_rise) begin
                    w_next  = S_LEN;
                    w_start = 1'b1;
                end
            end
            S_LEN: begin
                if (!w_ld_lvl) begin
                    w_next = S_ERR;
                end else if (w_cap) begin
                    w_store_len = w_len_ok;
                    w_next      = w_len_ok ? S_DATA : S_ERR;
                end
            end
            S_DATA: begin
                if (!w_ld_lvl) begin
                    w_next = S_ERR;
                end else if (w_cap) begin
                    w_wr = 1'b1;
`ifdef CPU_LOADER_CHECKSUM_EN
                    if (w_last) w_next = S_CHK;
`else
                    if (w_last) w_next = S_DONE;
`endif
                end
            end
`ifdef CPU_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (!w_ld_lvl) begin
                    w_next = S_ERR;
                end else if (w_cap) begin
                    w_next = (bus.data_in == r_chk) ? S_DONE : S_ERR;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_we    <= 1'b0;
            r_run   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
`ifdef CPU_LOADER_CHECKSUM_EN
            r_chk   <= '0;
`endif
        end else begin
            if (w_cap)           r_ack <= 1'b1;
            else if (!w_stb_lvl) r_ack <= 1'b0;
            r_we  <= w_wr;
            r_run <= (r_state == S_IDLE) || (r_state == S_DONE);
            if (w_wr)        r_wdata <= bus.data_in;
            if (w_store_len) r_len   <= w_len9[CW-1:0];
            // The address steps after the write cycle so it ends at L mod 2^ADDR_W.
            if (w_start) begin
                r_addr <= '0;
                r_cnt  <= '0;
`ifdef CPU_LOADER_CHECKSUM_EN
                r_chk  <= '0;
`endif
            end else begin
                if (r_we) r_addr <= r_addr + 1'b1;
                if (w_wr) begin
                    r_cnt <= w_cnt_inc;
`ifdef CPU_LOADER_CHECKSUM_EN
                    r_chk <= r_chk ^ bus.data_in;
`endif
                end
            end
        end
    end

    always_comb begin
        w_busy = (r_state == S_LEN) || (r_state == S_DATA);
`ifdef CPU_LOADER_CHECKSUM_EN
        if (r_state == S_CHK) w_busy = 1'b1;
`endif
    end

    assign bus.ack       = r_ack;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_run   = r_run;
    assign bus.busy      = w_busy;
    assign bus.err       = (r_state == S_ERR);

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed plus randomised bench for cpu_prog_loader against a frame-level
// model: expected write list, final status and address from the frame rules.
module tb_cpu_prog_loader;

`ifdef CPU_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int MAXP = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_prog_loader_if #(.ADDR_W(4)) bus ();

    cpu_prog_loader #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] wq[$];
    logic [7:0]  pl[MAXP];

    always @(negedge clk)
        if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        bus.data_in = b;
        bus.stb_in  = 1'b1;
        n = 0;
        while (bus.ack !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ack_rise", bus.ack, 1);
        bus.stb_in = 1'b0;
        n = 0;
        while (bus.ack !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ack_fall", bus.ack, 0);
        bus.data_in = 8'($urandom);
    endtask

    task automatic start_load();
        int n;
        @(negedge clk);
        bus.load_req = 1'b0;
        repeat (5) @(negedge clk);
        bus.load_req = 1'b1;
        n = 0;
        while (bus.busy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("start_busy", bus.busy, 1);
        check("start_err_clr", bus.err, 0);
        repeat (2) @(negedge clk);
        check("start_run_low", bus.cpu_run, 0);
    endtask

    task automatic do_frame(input int len, input logic [7:0] chk);
        int base;
        bit valid, ok;
        logic [7:0] x;
        valid = (len >= 1) && (len <= MAXP);
        x = 8'h00;
        if (valid) for (int i = 0; i < len; i++) x ^= pl[i];
        ok = valid && (!CHK_EN || chk == x);
        base = wq.size();
        start_load();
        send_byte(8'(len));
        if (valid) begin
            for (int i = 0; i < len; i++) send_byte(pl[i]);
            send_byte(chk);
        end
        repeat (6) @(negedge clk);
        check("wr_count", wq.size() - base, valid ? len : 0);
        if (valid)
            for (int i = 0; i < len; i++)
                if (base + i < wq.size())
                    check("wr_item", wq[base + i], {4'(i % MAXP), pl[i]});
        check("frame_err", bus.err, !ok);
        check("frame_run", bus.cpu_run, ok);
        check("frame_busy", bus.busy, 0);
        if (ok) check("frame_addr", bus.mem_addr, len % MAXP);
    endtask

    initial begin
        int base, len, n;
        logic [7:0] x;

        rst_n = 1'b0;
        bus.load_req = 1'b0;
        bus.stb_in   = 1'b0;
        bus.data_in  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ack", bus.ack, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_run", bus.cpu_run, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_run", bus.cpu_run, 1);

        pl[0] = 8'hA1; pl[1] = 8'h02; pl[2] = 8'h53;
        do_frame(3, 8'hF0);
        do_frame(3, 8'h00);
        do_frame(0, 8'h00);
        do_frame(17, 8'h00);
        x = 8'h00;
        for (int i = 0; i < MAXP; i++) begin
            pl[i] = 8'($urandom);
            x ^= pl[i];
        end
        do_frame(16, x);

        // Edge-accurate handshake timing, then an abort after two bytes.
        base = wq.size();
        start_load();
        send_byte(8'd4);
        @(negedge clk);
        bus.data_in = 8'h5C;
        bus.stb_in  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 3) check("t_ack_early", bus.ack, 0);
            if (k == 3) check("t_we_early", bus.mem_we, 0);
            if (k == 4) check("t_ack_rise", bus.ack, 1);
            if (k == 4) check("t_we_rise", bus.mem_we, 1);
            if (k == 4) check("t_wdata", bus.mem_wdata, 8'h5C);
            if (k == 4) check("t_waddr", bus.mem_addr, 0);
            if (k == 5) check("t_we_pulse", bus.mem_we, 0);
        end
        @(negedge clk);
        bus.stb_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) check("t_ack_hold", bus.ack, 1);
            if (k == 4) check("t_ack_fall", bus.ack, 0);
        end
        send_byte(8'h77);
        @(negedge clk);
        bus.load_req = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_err", bus.err, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_wr", wq.size() - base, 2);
        send_byte(8'h99);
        send_byte(8'h98);
        repeat (4) @(negedge clk);
        check("abort_discard", wq.size() - base, 2);
        check("abort_err_hold", bus.err, 1);

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, MAXP);
            x = 8'h00;
            for (int i = 0; i < len; i++) begin
                pl[i] = 8'($urandom);
                x ^= pl[i];
            end
            if ($urandom_range(0, 1) == 1) x ^= 8'($urandom_range(1, 255));
            do_frame(len, x);
        end

        // Reset while a write pulse is on the bus.
        start_load();
        send_byte(8'd5);
        send_byte(8'h11);
        @(negedge clk);
        bus.data_in = 8'h22;
        bus.stb_in  = 1'b1;
        n = 0;
        while (bus.mem_we !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_we_seen", bus.mem_we, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", bus.mem_we, 0);
        check("mid_rst_ack", bus.ack, 0);
        check("mid_rst_addr", bus.mem_addr, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_run", bus.cpu_run, 0);
        check("mid_rst_err", bus.err, 0);
        bus.load_req = 1'b0;
        bus.stb_in   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_run0", bus.cpu_run, 0);
        @(posedge clk); #1;
        check("post_rst_run1", bus.cpu_run, 1);
        check("post_rst_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_prog_loader.md
# cpu_prog_loader

Byte-stream program loader sitting directly upstream of the CPU core inside `tt_um_cpu_madhav_malhotra`. It accepts a framed program from the host over the dedicated input pins using a four-phase strobe/ack handshake, and writes it into the core's instruction memory. It holds the core out of execution while loading. The frame is: length byte, payload bytes, then an optional XOR checksum byte.

## Interface
- `ADDR_W`, 4: instruction-memory address width; maximum payload is 2^ADDR_W bytes.
- `SYNC_STAGES`, 2: flop count of each input synchroniser (≥2).

- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low (one clock; reset polarity and synchronicity fixed)
- `load_req`  in  1  asynchronous level from the host; a rising edge starts a load
- `stb_in`  in  1  asynchronous host byte strobe
- `data_in`  in  8  host byte; held stable from `stb_in` rise until `ack` rises
- `ack`  out  1  handshake acknowledge to the host
- `mem_we`  out  1  one-cycle instruction-memory write pulse
- `mem_addr`  out  ADDR_W  write address
- `mem_wdata`  out  8  write data
- `cpu_run`  out  1  core may execute when high
- `busy`  out  1  load in progress
- `err`  out  1  last load failed; sticky until the next load starts

## Operation
- States: IDLE, LEN, DATA, CHK, DONE, ERR. Reset state is IDLE.
- Reset values: all outputs are 0, `mem_addr`=0, and the length, count and checksum registers are 0.
- `cpu_run`=1 in IDLE and DONE; 0 elsewhere. `busy`=1 in LEN/DATA/CHK. `err`=1 only in ERR.
- A synchronised `load_req` rising edge in IDLE, DONE or ERR moves to LEN and clears `mem_addr`, count and checksum.
- A synchronised `load_req` low while in LEN, DATA or CHK aborts to ERR. A rising edge of `load_req` in those states is impossible, since it is already high.
- A byte is "captured" in the cycle a synchronised `stb_in` rising edge is detected.
- **LEN:**
  - A captured value L with 1 ≤ L ≤ 2^ADDR_W stores L and moves to DATA.
  - L=0 or L>2^ADDR_W moves to ERR.
  - No memory write occurs in LEN.
- **DATA:** each capture does the following:
  - writes `data_in` at `mem_addr`;
  - XORs the byte into the checksum;
  - increments the count.
  - After the L-th byte: with checksum enabled, go to CHK; otherwise go to DONE.
  - `mem_addr` increments after each write and wraps to 0 modulo 2^ADDR_W. It ends at L mod 2^ADDR_W.
- **CHK:** a captured byte equal to the running XOR goes to DONE; otherwise go to ERR. No memory write occurs.
- Captures in IDLE, DONE or ERR are handshaken but discarded.
- Memory contents written before an abort are not rolled back.
- Arithmetic: the length compare uses 9 bits; the count register is ADDR_W+1 bits wide.

## Timing
- `stb_in` and `load_req` each pass through SYNC_STAGES flops; the edge detect uses one further flop.
- Capture occurs SYNC_STAGES+1 clock edges after the first edge that samples `stb_in` high.
- `ack`, `mem_we`, `mem_addr` and `mem_wdata` are registered and update on the edge following capture:
  - `mem_we` is high for exactly one cycle;
  - the address and data are valid in that same cycle.
- `ack` falls on the edge after synchronised `stb_in` is seen low.
- Host rule: raise `stb_in`, wait for `ack`=1, lower `stb_in`, wait for `ack`=0.
- State transitions take effect on the edge after capture or detection. `cpu_run` rises one cycle after entering DONE.
- Simultaneous events in one cycle: `load_req` abort wins over a strobe capture, and no write occurs.
- Reset asserted mid-load: immediate return to IDLE. `ack` and `mem_we` drop asynchronously.

## Configuration
- `CPU_LOADER_CHECKSUM_EN` defined: the CHK state exists and the trailing checksum byte is required.
- `CPU_LOADER_CHECKSUM_EN` undefined: CHK and the checksum register are removed, and DATA goes to DONE after the L-th byte.

## Structure
- Package `cpu_loader_pkg`: the state enum `loader_state_t`, and a constant for the maximum payload derived from ADDR_W.
- Sub-module `sync_edge` (SYNC_STAGES synchroniser plus rising-edge detect), instantiated once for `stb_in` and once for `load_req`.

## Test plan
- **Nominal load:** reset, raise `load_req`, send 3, 0xA1, 0x02, 0x53, checksum 0xF0.
  - Writes {0:A1, 1:02, 2:53}, one `mem_we` pulse each.
  - DONE, `cpu_run`=1, `err`=0.
- **Bad checksum:** same payload with checksum 0x00.
  - Three writes, then ERR, `err`=1, `cpu_run`=0.
  - A new `load_req` edge clears `err`.
- **Length bounds:** L=0 → ERR with no writes. L=17 → ERR. L=16 → 16 writes, `mem_addr` wraps to 0 in DONE.
- **Abort:** drop `load_req` after the 2nd payload byte.
  - ERR with no further writes.
  - Later strobes still get `ack` but are discarded.
- **Handshake timing:** with SYNC_STAGES=2, `ack` and `mem_we` rise on the 4th edge after `stb_in` first sampled high. `ack` falls 4 edges after `stb_in` is sampled low.
- **Reset mid-DATA:** assert `rst_n`=0 between bytes.
  - All outputs go to reset values immediately.
  - After release: IDLE, `cpu_run`=1 one cycle later.
